// File: rtl/dbus_decoder_pkg.sv
// dbus_decoder_pkg -- shared definitions for the data-bus decoder.
//   State encoding, error-cause encoding, the default error read data,
//   the stall counter width and the error record layout.
package dbus_decoder_pkg;

  // Decoder FSM states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_ABORT = 2'd2;

  // errCode causes
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_UNMAPPED = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

  // Read data returned to the master for any failed access
  localparam logic [31:0] DBUS_ERR_DATA = 32'hDEAD_BEEF;

  localparam int STALL_W = 16;

  // Most recent error, as exposed on errAddr/errCode
  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  code;
  } err_rec_t;

  // Index width for an n-entry select; never below one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dbus_decoder_addr_match_onehot.sv
// addr_match_onehot -- combinational address decode for the data bus.
//   addr    : request byte address
//   hit     : one-hot hit vector, lowest matching slave wins
//   idx     : binary index of the winning slave (0 when none)
//   any_hit : at least one slave matched
// Slave i matches when (addr & SLV_MASK[i]) == SLV_BASE[i].
module addr_match_onehot
  import dbus_decoder_pkg::*;
#(
  parameter int                 NSLV     = 6,
  parameter logic [NSLV*32-1:0] SLV_BASE = '0,
  parameter logic [NSLV*32-1:0] SLV_MASK = '0,
  parameter int                 IDX_W    = idx_width(NSLV)
) (
  input  logic [31:0]      addr,
  output logic [NSLV-1:0]  hit,
  output logic [IDX_W-1:0] idx,
  output logic             any_hit
);

  logic [NSLV-1:0] raw;
  // seen[i]: some slave below i already matched, so i is masked off
  logic [NSLV:0]   seen;

  assign seen[0] = 1'b0;

  for (genvar i = 0; i < NSLV; i++) begin : g_slv
    assign raw[i]    = (addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32];
    assign seen[i+1] = seen[i] | raw[i];
    assign hit[i]    = raw[i] & ~seen[i];
  end

  assign any_hit = seen[NSLV];

  // hit is one-hot, so an OR-style scan yields the single set index
  always_comb begin
    idx = '0;
    for (int i = 0; i < NSLV; i++)
      if (hit[i]) idx = IDX_W'(i);
  end

endmodule

// File: rtl/dbus_decoder.sv
// dbus_decoder -- single-master data-bus decoder with stall timeout.
//   clk, rst   : clock, synchronous active-high reset
//   masterEN   : master request strobe
//   addrBus    : request byte address
//   dataToCPU  : read data, one cycle after an accepted request
//   nakDBus    : stall back to the master (hit slave's nak)
//   busErr     : one-cycle pulse the cycle after an error
//   errAddr    : address of the most recent error
//   errCode    : cause of the most recent error (none/unmapped/timeout)
//   slvEN      : per-slave enable
//   slvData    : per-slave read data, slave i at [32i+31:32i]
//   slvNak     : per-slave stall
// A slave that naks for TIMEOUT consecutive WAIT cycles gets the transfer
// aborted: one ABORT cycle with no enables and no stall, then an error.
module dbus_decoder
  import dbus_decoder_pkg::*;
#(
  parameter int                 NSLV     = 6,
  parameter logic [NSLV*32-1:0] SLV_BASE = '0,
  parameter logic [NSLV*32-1:0] SLV_MASK = '0,
  parameter int                 TIMEOUT  = 255,
  parameter logic [31:0]        ERR_DATA = DBUS_ERR_DATA
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 masterEN,
  input  logic [31:0]          addrBus,
  output logic [31:0]          dataToCPU,
  output logic                 nakDBus,
  output logic                 busErr,
  output logic [31:0]          errAddr,
  output logic [1:0]           errCode,
  output logic [NSLV-1:0]      slvEN,
  input  logic [NSLV*32-1:0]   slvData,
  input  logic [NSLV-1:0]      slvNak
);

  localparam int IDX_W = idx_width(NSLV);
  localparam logic [STALL_W:0] TIMEOUT_V = (STALL_W+1)'(TIMEOUT);

  logic [NSLV-1:0][31:0] slv_data_a;
  logic [NSLV-1:0]       hit;
  logic [IDX_W-1:0]      hit_idx;
  logic                  any_hit;

  logic [1:0]            state, state_nxt;
  logic [STALL_W-1:0]    stall_cnt, stall_cnt_nxt;
  logic [STALL_W:0]      stall_inc;
  logic [IDX_W-1:0]      sel_idx;
  logic                  sel_err;
  err_rec_t              err_q;

  logic                  active, aborting, nak_hit, accept, unmapped;

  assign slv_data_a = slvData;

  addr_match_onehot #(
    .NSLV     (NSLV),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK),
    .IDX_W    (IDX_W)
  ) u_match (
    .addr    (addrBus),
    .hit     (hit),
    .idx     (hit_idx),
    .any_hit (any_hit)
  );

  assign active    = (state == ST_IDLE) || (state == ST_WAIT);
  assign aborting  = (state == ST_ABORT);
  assign nak_hit   = |(hit & slvNak);
  assign nakDBus   = masterEN & nak_hit & active;
  assign slvEN     = {NSLV{masterEN & ~aborting}} & hit;
  assign accept    = masterEN & ~nakDBus;
  assign unmapped  = masterEN & ~any_hit & ~aborting;
  assign stall_inc = {1'b0, stall_cnt} + 1'b1;

  // Counter clears on every path except a continuing stall in WAIT,
  // including the WAIT->ABORT step.
  always_comb begin
    state_nxt     = state;
    stall_cnt_nxt = '0;
    case (state)
      ST_IDLE: if (nakDBus) state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (!nakDBus)                    state_nxt = ST_IDLE;
        else if (stall_inc == TIMEOUT_V) state_nxt = ST_ABORT;
        else                             stall_cnt_nxt = stall_inc[STALL_W-1:0];
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      stall_cnt <= '0;
      sel_idx   <= '0;
      sel_err   <= 1'b0;
      busErr    <= 1'b0;
      err_q     <= '0;
    end else begin
      state     <= state_nxt;
      stall_cnt <= stall_cnt_nxt;
      busErr    <= aborting | unmapped;
      // ABORT forces error data regardless of whether the master still
      // strobes; otherwise the select only moves on an accepted cycle.
      if (aborting) begin
        sel_err <= 1'b1;
      end else if (accept) begin
        sel_idx <= hit_idx;
        sel_err <= ~any_hit;
      end
      if (aborting)
        err_q <= '{addr: addrBus, code: ERR_TIMEOUT};
      else if (unmapped)
        err_q <= '{addr: addrBus, code: ERR_UNMAPPED};
    end
  end

  // ABORT cycle already shows error data so the master never samples a
  // stale slave word when the stall is released.
  always_comb begin
    if (rst)                       dataToCPU = slv_data_a[0];
    else if (sel_err || aborting)  dataToCPU = ERR_DATA;
    else                           dataToCPU = slv_data_a[sel_idx];
  end

  assign errAddr = err_q.addr;
  assign errCode = err_q.code;

endmodule

// File: tb/tb_dbus_decoder.sv
// tb_dbus_decoder -- directed self-checking bench for dbus_decoder.
//   Map: slave0 0x4xxx_xxxx, slave1 0x2xxx_xxxx, slave2 0xBFC0_0000/16K,
//   slave3 0x4000_0000-0x7FFF_FFFF (overlaps slave0). TIMEOUT=4.
module tb_dbus_decoder;

  localparam int NSLV = 4;
  localparam logic [NSLV*32-1:0] BASE =
    {32'h4000_0000, 32'hBFC0_0000, 32'h2000_0000, 32'h4000_0000};
  localparam logic [NSLV*32-1:0] MASK =
    {32'hC000_0000, 32'hFFFF_C000, 32'hF000_0000, 32'hF000_0000};
  localparam logic [31:0] D0 = 32'hD0D0_0000;
  localparam logic [31:0] D1 = 32'hD1D1_0001;
  localparam logic [31:0] D2 = 32'hD2D2_0002;
  localparam logic [31:0] D3 = 32'hD3D3_0003;
  localparam logic [31:0] EDATA = 32'hDEAD_BEEF;

  logic                clk = 1'b0;
  logic                rst;
  logic                masterEN;
  logic [31:0]         addrBus;
  logic [31:0]         dataToCPU;
  logic                nakDBus;
  logic                busErr;
  logic [31:0]         errAddr;
  logic [1:0]          errCode;
  logic [NSLV-1:0]     slvEN;
  logic [NSLV*32-1:0]  slvData;
  logic [NSLV-1:0]     slvNak;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dbus_decoder #(
    .NSLV     (NSLV),
    .SLV_BASE (BASE),
    .SLV_MASK (MASK),
    .TIMEOUT  (4),
    .ERR_DATA (32'hDEAD_BEEF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .masterEN  (masterEN),
    .addrBus   (addrBus),
    .dataToCPU (dataToCPU),
    .nakDBus   (nakDBus),
    .busErr    (busErr),
    .errAddr   (errAddr),
    .errCode   (errCode),
    .slvEN     (slvEN),
    .slvData   (slvData),
    .slvNak    (slvNak)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; masterEN = 1'b0; addrBus = '0; slvNak = '0;
    slvData = {D3, D2, D1, D0};
    tick(); tick();
    checks++; if (busErr !== 1'b0) begin errors++; $display("FAIL rst_busErr got %h want 0", busErr); end
    checks++; if (errCode !== 2'd0) begin errors++; $display("FAIL rst_errCode got %h want 0", errCode); end
    checks++; if (errAddr !== 32'h0) begin errors++; $display("FAIL rst_errAddr got %h want 0", errAddr); end
    checks++; if (dataToCPU !== D0) begin errors++; $display("FAIL rst_data got %h want %h", dataToCPU, D0); end
    checks++; if (nakDBus !== 1'b0) begin errors++; $display("FAIL rst_nak got %h want 0", nakDBus); end
    checks++; if (slvEN !== 4'b0000) begin errors++; $display("FAIL rst_slvEN got %b want 0000", slvEN); end
    masterEN = 1'b1; addrBus = 32'hBFC0_0010; #1;
    checks++; if (slvEN !== 4'b0100) begin errors++; $display("FAIL rst_slvEN_follow got %b want 0100", slvEN); end
    checks++; if (dataToCPU !== D0) begin errors++; $display("FAIL rst_data_hold got %h want %h", dataToCPU, D0); end
    masterEN = 1'b0; rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_read();
    masterEN = 1'b1; addrBus = 32'hBFC0_0010; #1;
    checks++; if (slvEN !== 4'b0100) begin errors++; $display("FAIL basic_slvEN got %b want 0100", slvEN); end
    checks++; if (nakDBus !== 1'b0) begin errors++; $display("FAIL basic_nak got %h want 0", nakDBus); end
    tick(); masterEN = 1'b0; #1;
    checks++; if (dataToCPU !== D2) begin errors++; $display("FAIL basic_data got %h want %h", dataToCPU, D2); end
    checks++; if (busErr !== 1'b0) begin errors++; $display("FAIL basic_busErr got %h want 0", busErr); end
    tick();
    checks++; if (dataToCPU !== D2) begin errors++; $display("FAIL basic_hold got %h want %h", dataToCPU, D2); end
    slvData[95:64] = 32'h2222_AAAA; #1;
    checks++; if (dataToCPU !== 32'h2222_AAAA) begin errors++; $display("FAIL basic_track got %h want 2222aaaa", dataToCPU); end
    slvData[95:64] = D2;
  endtask

  task automatic test_back_to_back();
    masterEN = 1'b1; addrBus = 32'h2000_0004; #1;
    checks++; if (slvEN !== 4'b0010) begin errors++; $display("FAIL b2b_en1 got %b want 0010", slvEN); end
    tick(); addrBus = 32'h4100_0000; #1;
    checks++; if (dataToCPU !== D1) begin errors++; $display("FAIL b2b_data1 got %h want %h", dataToCPU, D1); end
    checks++; if (slvEN !== 4'b0001) begin errors++; $display("FAIL b2b_en0 got %b want 0001", slvEN); end
    tick(); addrBus = 32'h5000_0000; #1;
    checks++; if (dataToCPU !== D0) begin errors++; $display("FAIL b2b_data0 got %h want %h", dataToCPU, D0); end
    checks++; if (slvEN !== 4'b1000) begin errors++; $display("FAIL b2b_en3 got %b want 1000", slvEN); end
    tick(); masterEN = 1'b0; #1;
    checks++; if (dataToCPU !== D3) begin errors++; $display("FAIL b2b_data3 got %h want %h", dataToCPU, D3); end
  endtask

  task automatic test_overlap();
    masterEN = 1'b1; addrBus = 32'h4000_0100; #1;
    checks++; if (slvEN !== 4'b0001) begin errors++; $display("FAIL ovl_slvEN got %b want 0001", slvEN); end
    tick(); masterEN = 1'b0; #1;
    checks++; if (dataToCPU !== D0) begin errors++; $display("FAIL ovl_data got %h want %h", dataToCPU, D0); end
  endtask

  task automatic test_unmapped();
    masterEN = 1'b1; addrBus = 32'h1234_5678; #1;
    checks++; if (nakDBus !== 1'b0) begin errors++; $display("FAIL unm_nak got %h want 0", nakDBus); end
    checks++; if (slvEN !== 4'b0000) begin errors++; $display("FAIL unm_slvEN got %b want 0000", slvEN); end
    tick(); masterEN = 1'b0; #1;
    checks++; if (dataToCPU !== EDATA) begin errors++; $display("FAIL unm_data got %h want %h", dataToCPU, EDATA); end
    checks++; if (busErr !== 1'b1) begin errors++; $display("FAIL unm_busErr got %h want 1", busErr); end
    checks++; if (errCode !== 2'd1) begin errors++; $display("FAIL unm_errCode got %h want 1", errCode); end
    checks++; if (errAddr !== 32'h1234_5678) begin errors++; $display("FAIL unm_errAddr got %h want 12345678", errAddr); end
    tick();
    checks++; if (busErr !== 1'b0) begin errors++; $display("FAIL unm_pulse got %h want 0", busErr); end
    checks++; if (errCode !== 2'd1) begin errors++; $display("FAIL unm_code_hold got %h want 1", errCode); end
  endtask

  task automatic test_nak_short();
    masterEN = 1'b1; addrBus = 32'h2000_0000; slvNak = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (nakDBus !== 1'b1) begin errors++; $display("FAIL nak3_cyc%0d got %h want 1", i, nakDBus); end
      tick();
    end
    slvNak = 4'b0000; #1;
    checks++; if (nakDBus !== 1'b0) begin errors++; $display("FAIL nak3_release got %h want 0", nakDBus); end
    tick(); masterEN = 1'b0; #1;
    checks++; if (dataToCPU !== D1) begin errors++; $display("FAIL nak3_data got %h want %h", dataToCPU, D1); end
    checks++; if (busErr !== 1'b0) begin errors++; $display("FAIL nak3_busErr got %h want 0", busErr); end
  endtask

  task automatic test_timeout();
    masterEN = 1'b1; addrBus = 32'h2000_0040; slvNak = 4'b0010;
    // one IDLE stall cycle plus four WAIT cycles
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (nakDBus !== 1'b1) begin errors++; $display("FAIL to_nak%0d got %h want 1", i, nakDBus); end
      checks++; if (slvEN !== 4'b0010) begin errors++; $display("FAIL to_en%0d got %b want 0010", i, slvEN); end
      tick();
    end
    checks++; if (nakDBus !== 1'b0) begin errors++; $display("FAIL to_abort_nak got %h want 0", nakDBus); end
    checks++; if (slvEN !== 4'b0000) begin errors++; $display("FAIL to_abort_en got %b want 0000", slvEN); end
    checks++; if (dataToCPU !== EDATA) begin errors++; $display("FAIL to_abort_data got %h want %h", dataToCPU, EDATA); end
    checks++; if (busErr !== 1'b0) begin errors++; $display("FAIL to_abort_busErr got %h want 0", busErr); end
    tick(); masterEN = 1'b0; slvNak = 4'b0000; #1;
    checks++; if (busErr !== 1'b1) begin errors++; $display("FAIL to_busErr got %h want 1", busErr); end
    checks++; if (errCode !== 2'd2) begin errors++; $display("FAIL to_errCode got %h want 2", errCode); end
    checks++; if (errAddr !== 32'h2000_0040) begin errors++; $display("FAIL to_errAddr got %h want 20000040", errAddr); end
    checks++; if (dataToCPU !== EDATA) begin errors++; $display("FAIL to_data got %h want %h", dataToCPU, EDATA); end
    tick();
    checks++; if (busErr !== 1'b0) begin errors++; $display("FAIL to_pulse got %h want 0", busErr); end
  endtask

  task automatic test_reset_mid();
    // reset on the 2nd stall cycle (first WAIT cycle)
    masterEN = 1'b1; addrBus = 32'h2000_0000; slvNak = 4'b0010;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; masterEN = 1'b0; slvNak = 4'b0000; #1;
    checks++; if (busErr !== 1'b0) begin errors++; $display("FAIL rw_busErr got %h want 0", busErr); end
    checks++; if (errCode !== 2'd0) begin errors++; $display("FAIL rw_errCode got %h want 0", errCode); end
    checks++; if (errAddr !== 32'h0) begin errors++; $display("FAIL rw_errAddr got %h want 0", errAddr); end
    checks++; if (dataToCPU !== D0) begin errors++; $display("FAIL rw_data got %h want %h", dataToCPU, D0); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (busErr !== 1'b0) begin errors++; $display("FAIL rw_quiet%0d got %h want 0", i, busErr); end
    end
    // reset landing in the ABORT cycle
    masterEN = 1'b1; addrBus = 32'h2000_0080; slvNak = 4'b0010;
    repeat (5) tick();
    checks++; if (nakDBus !== 1'b0) begin errors++; $display("FAIL ra_in_abort got %h want 0", nakDBus); end
    rst = 1'b1;
    tick();
    rst = 1'b0; masterEN = 1'b0; slvNak = 4'b0000; #1;
    checks++; if (busErr !== 1'b0) begin errors++; $display("FAIL ra_busErr got %h want 0", busErr); end
    checks++; if (errCode !== 2'd0) begin errors++; $display("FAIL ra_errCode got %h want 0", errCode); end
    masterEN = 1'b1; addrBus = 32'hBFC0_0010; #1;
    checks++; if (slvEN !== 4'b0100) begin errors++; $display("FAIL ra_idle_en got %b want 0100", slvEN); end
    tick(); masterEN = 1'b0; #1;
    checks++; if (dataToCPU !== D2) begin errors++; $display("FAIL ra_data got %h want %h", dataToCPU, D2); end
    checks++; if (busErr !== 1'b0) begin errors++; $display("FAIL ra_quiet got %h want 0", busErr); end
  endtask

  task automatic test_err_overwrite();
    masterEN = 1'b1; addrBus = 32'h1111_0000;
    tick(); addrBus = 32'h3333_0000; #1;
    checks++; if (busErr !== 1'b1) begin errors++; $display("FAIL ow_busErr1 got %h want 1", busErr); end
    checks++; if (errAddr !== 32'h1111_0000) begin errors++; $display("FAIL ow_addr1 got %h want 11110000", errAddr); end
    tick(); masterEN = 1'b0; #1;
    checks++; if (busErr !== 1'b1) begin errors++; $display("FAIL ow_busErr2 got %h want 1", busErr); end
    checks++; if (errAddr !== 32'h3333_0000) begin errors++; $display("FAIL ow_addr2 got %h want 33330000", errAddr); end
    checks++; if (errCode !== 2'd1) begin errors++; $display("FAIL ow_code got %h want 1", errCode); end
    tick();
    checks++; if (busErr !== 1'b0) begin errors++; $display("FAIL ow_end got %h want 0", busErr); end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_back_to_back();
    test_overlap();
    test_unmapped();
    test_nak_short();
    test_timeout();
    test_reset_mid();
    test_err_overwrite();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
